// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-port (CPU / DMA) arbiter onto an asynchronous SRAM with a
//             four-phase IDLE/SETUP/STROBE/DONE access cycle.
//  Option   : RAM_ARBITER_FIXED_PRIO_EN - CPU always wins ties (else round-robin)
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              reset,
   // CPU requester
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   // DMA requester
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   // RAM
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_cs_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic                r_gnt_dma;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dma_rdata;
   logic                w_any_req;
   logic                w_pick_dma;
   logic                w_grant;

   assign w_any_req = cpu_req | dma_req;
   assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef RAM_ARBITER_FIXED_PRIO_EN
   assign w_pick_dma = dma_req & ~cpu_req;
`else
   // Round-robin: on a tie, the side that did not win last time goes first.
   logic r_last_dma;

   assign w_pick_dma = dma_req & (~cpu_req | ~r_last_dma);

   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_last_dma <= 1'b0;
      end else if (w_grant) begin
         r_last_dma <= w_pick_dma;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      ram_cs_n = 1'b1;
      ram_oe_n = 1'b1;
      ram_we_n = 1'b1;
      cpu_ack  = 1'b0;
      dma_ack  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_next = SETUP;
            end
         end
         SETUP: begin
            w_next   = STROBE;
            ram_cs_n = 1'b0;
            ram_oe_n = r_we;
         end
         STROBE: begin
            w_next   = DONE;
            ram_cs_n = 1'b0;
            ram_oe_n = r_we;
            ram_we_n = ~r_we;
         end
         DONE: begin
            w_next  = IDLE;
            cpu_ack = ~r_gnt_dma;
            dma_ack = r_gnt_dma;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Request latch and read-data capture; only the granted side's rdata moves.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_we        <= 1'b0;
         r_gnt_dma   <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_gnt_dma <= w_pick_dma;
            r_we      <= w_pick_dma ? dma_we    : cpu_we;
            r_addr    <= w_pick_dma ? dma_addr  : cpu_addr;
            r_wdata   <= w_pick_dma ? dma_wdata : cpu_wdata;
         end
         if ((r_state == STROBE) && !r_we) begin
            if (r_gnt_dma) begin
               r_dma_rdata <= ram_rdata;
            end else begin
               r_cpu_rdata <= ram_rdata;
            end
         end
      end
   end

   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Table-driven cycle vectors plus directed multi-cycle sequences
//             for ram_arbiter (honours RAM_ARBITER_FIXED_PRIO_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;
   localparam int AW = 15;
   localparam int DW = 8;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
   localparam bit c_fixed = 1'b1;
`else
   localparam bit c_fixed = 1'b0;
`endif

   // {cs_n, oe_n, we_n, busy, cpu_ack, dma_ack}
   localparam logic [5:0] c_idle = 6'b111000;
   localparam logic [5:0] c_sw   = 6'b011100;
   localparam logic [5:0] c_tw   = 6'b010100;
   localparam logic [5:0] c_sr   = 6'b001100;
   localparam logic [5:0] c_tr   = 6'b001100;
   localparam logic [5:0] c_dc   = 6'b111110;
   localparam logic [5:0] c_dd   = 6'b111101;
   localparam logic [AW-1:0] Z15 = '0;
   localparam logic [DW-1:0] Z8  = '0;

   logic          i_clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] cpu_addr, dma_addr, ram_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata, ram_wdata, ram_rdata, cpu_rdata, dma_rdata;
   logic          cpu_ack, dma_ack, ram_cs_n, ram_oe_n, ram_we_n, busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          rst, creq, cwe;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwd;
      logic          dreq, dwe;
      logic [AW-1:0] daddr;
      logic [DW-1:0] dwd, rrd;
      logic [5:0]    ectl;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewd, ecrd, edrd;
   } vec_t;

   vec_t vq[$];

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk     (i_clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_cs_n  (ram_cs_n),
      .ram_oe_n  (ram_oe_n),
      .ram_we_n  (ram_we_n),
      .busy      (busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic rst, creq, cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input logic dreq, dwe,
                      input logic [AW-1:0] daddr, input logic [DW-1:0] dwd, rrd,
                      input logic [5:0] ectl, input logic [AW-1:0] eaddr,
                      input logic [DW-1:0] ewd, ecrd, edrd);
      vec_t v;
      v.rst = rst;   v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe;   v.daddr = daddr; v.dwd = dwd; v.rrd = rrd;
      v.ectl = ectl; v.eaddr = eaddr; v.ewd = ewd; v.ecrd = ecrd; v.edrd = edrd;
      vq.push_back(v);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            n, dseen, ca, da;
      logic          got;

      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = Z15; cpu_wdata = Z8;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = Z15; dma_wdata = Z8;
      ram_rdata = Z8;

      // reset state
      add(1'b1, 1'b0,1'b0,Z15,Z8, 1'b0,1'b0,Z15,Z8, Z8, c_idle,Z15,Z8,Z8,Z8);
      // CPU write 0x1234 / 0xA5
      add(1'b0, 1'b1,1'b1,15'h1234,8'hA5, 1'b0,1'b0,Z15,Z8, Z8, c_sw,15'h1234,8'hA5,Z8,Z8);
      add(1'b0, 1'b1,1'b1,15'h1234,8'hA5, 1'b0,1'b0,Z15,Z8, Z8, c_tw,15'h1234,8'hA5,Z8,Z8);
      add(1'b0, 1'b1,1'b1,15'h1234,8'hA5, 1'b0,1'b0,Z15,Z8, Z8, c_dc,15'h1234,8'hA5,Z8,Z8);
      add(1'b0, 1'b0,1'b1,15'h1234,8'hA5, 1'b0,1'b0,Z15,Z8, Z8, c_idle,15'h1234,8'hA5,Z8,Z8);
      // DMA read 0x7FFF, RAM returns 0x3C
      add(1'b0, 1'b0,1'b0,Z15,Z8, 1'b1,1'b0,15'h7FFF,8'h77, Z8,    c_sr,15'h7FFF,8'h77,Z8,Z8);
      add(1'b0, 1'b0,1'b0,Z15,Z8, 1'b1,1'b0,15'h7FFF,8'h77, 8'h3C, c_tr,15'h7FFF,8'h77,Z8,Z8);
      add(1'b0, 1'b0,1'b0,Z15,Z8, 1'b1,1'b0,15'h7FFF,8'h77, 8'h3C, c_dd,15'h7FFF,8'h77,Z8,8'h3C);
      add(1'b0, 1'b0,1'b0,Z15,Z8, 1'b0,1'b0,15'h7FFF,8'h77, Z8,    c_idle,15'h7FFF,8'h77,Z8,8'h3C);
      // CPU read 0x0001, address moves to 0x0002 after sampling
      add(1'b0, 1'b1,1'b0,15'h0001,8'h99, 1'b0,1'b0,Z15,Z8, Z8,    c_sr,15'h0001,8'h99,Z8,8'h3C);
      add(1'b0, 1'b1,1'b0,15'h0002,8'h99, 1'b0,1'b0,Z15,Z8, 8'h5A, c_tr,15'h0001,8'h99,Z8,8'h3C);
      add(1'b0, 1'b1,1'b0,15'h0002,8'h99, 1'b0,1'b0,Z15,Z8, 8'h5A, c_dc,15'h0001,8'h99,8'h5A,8'h3C);
      add(1'b0, 1'b0,1'b0,15'h0002,8'h99, 1'b0,1'b0,Z15,Z8, Z8,    c_idle,15'h0001,8'h99,8'h5A,8'h3C);
      // reset during STROBE of a CPU write
      add(1'b0, 1'b1,1'b1,15'h0ABC,8'hC3, 1'b0,1'b0,Z15,Z8, Z8, c_sw,15'h0ABC,8'hC3,8'h5A,8'h3C);
      add(1'b0, 1'b1,1'b1,15'h0ABC,8'hC3, 1'b0,1'b0,Z15,Z8, Z8, c_tw,15'h0ABC,8'hC3,8'h5A,8'h3C);
      add(1'b1, 1'b1,1'b1,15'h0ABC,8'hC3, 1'b0,1'b0,Z15,Z8, Z8, c_idle,Z15,Z8,Z8,Z8);
      add(1'b0, 1'b0,1'b1,15'h0ABC,8'hC3, 1'b0,1'b0,Z15,Z8, Z8, c_idle,Z15,Z8,Z8,Z8);
      // both requesters held high after reset: DMA,CPU,DMA,CPU (CPU only if fixed)
      a = Z15; d = Z8;
      for (int t = 0; t < 4; t++) begin
         w = c_fixed ? 1'b0 : ((t % 2) == 0);
         a = w ? 15'h0200 : 15'h0100;
         d = w ? 8'h22 : 8'h11;
         add(1'b0, 1'b1,1'b1,15'h0100,8'h11, 1'b1,1'b1,15'h0200,8'h22, Z8, c_sw,a,d,Z8,Z8);
         add(1'b0, 1'b1,1'b1,15'h0100,8'h11, 1'b1,1'b1,15'h0200,8'h22, Z8, c_tw,a,d,Z8,Z8);
         add(1'b0, 1'b1,1'b1,15'h0100,8'h11, 1'b1,1'b1,15'h0200,8'h22, Z8, w ? c_dd : c_dc,a,d,Z8,Z8);
         add(1'b0, 1'b1,1'b1,15'h0100,8'h11, 1'b1,1'b1,15'h0200,8'h22, Z8, c_idle,a,d,Z8,Z8);
      end
      add(1'b0, 1'b0,1'b1,15'h0100,8'h11, 1'b0,1'b1,15'h0200,8'h22, Z8, c_idle,a,d,Z8,Z8);

      tick();
      tick();
      for (int i = 0; i < vq.size(); i++) begin
         reset     = vq[i].rst;
         cpu_req   = vq[i].creq;  cpu_we = vq[i].cwe;
         cpu_addr  = vq[i].caddr; cpu_wdata = vq[i].cwd;
         dma_req   = vq[i].dreq;  dma_we = vq[i].dwe;
         dma_addr  = vq[i].daddr; dma_wdata = vq[i].dwd;
         ram_rdata = vq[i].rrd;
         tick();
         check($sformatf("vec%0d", i),
               64'({ram_cs_n, ram_oe_n, ram_we_n, busy, cpu_ack, dma_ack,
                    ram_addr, ram_wdata, cpu_rdata, dma_rdata}),
               64'({vq[i].ectl, vq[i].eaddr, vq[i].ewd, vq[i].ecrd, vq[i].edrd}));
      end

      // worst-case CPU wait when both request together right after reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0033;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0044;
      n = 0; dseen = 0; got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         tick();
         if (dma_ack) dseen++;
         if (cpu_ack) begin
            got = 1'b1;
            n   = k;
         end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      check("cpu_wait_edges", 64'(n), c_fixed ? 64'd3 : 64'd7);
      check("dma_acks_before_cpu", 64'(dseen), c_fixed ? 64'd0 : 64'd1);
      tick();

      // requests changing mid-access are ignored until the next IDLE
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0005; cpu_wdata = 8'h06;
      ca = 0; da = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) begin
            cpu_req  = 1'b0;
            dma_req  = 1'b1;
            dma_we   = 1'b0;
            dma_addr = 15'h0009;
         end
         if (cpu_ack && ca == 0) ca = k;
         if (dma_ack && da == 0) da = k;
      end
      dma_req = 1'b0;
      check("ignored_change_cpu_ack", 64'(ca), 64'd3);
      check("ignored_change_dma_ack", 64'(da), 64'd7);
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
